// File: rtl/placement_pkg.sv
// placement_pkg: shared constants, scan state encoding and record type for the placer readback
package placement_pkg;
  localparam int DW          = 32;
  localparam int N_DEF       = 12;
  localparam int N_NODES_DEF = 128;
  localparam int GRID_AW_DEF = 12;
  localparam int POS_AW_DEF  = 7;
  localparam logic [DW-1:0] EMPTY = '1;
  typedef enum logic [3:0] {
    IDLE, G_RD, G_WT, P_RD, P_WT, CHECK, EMIT, G_NEXT, S_RD, S_WT, S_CHK, DONE
  } state_t;
  typedef struct packed {
    logic [DW-1:0] node;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          err;
  } rec_t;
endpackage

// File: rtl/placement_grid_addr_gen.sv
// placement_grid_addr_gen: row/col walker with running linear address x*N+y and last-cell flag
module placement_grid_addr_gen #(
  parameter int N  = 12,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic [AW-1:0] addr,
  output logic          last
);
  logic [AW-1:0] r_row, r_col, r_addr;
  logic          w_col_end;
  assign w_col_end = r_col == AW'(N - 1);
  assign last      = r_addr == AW'(N * N - 1);
  assign row       = r_row;
  assign col       = r_col;
  assign addr      = r_addr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (clr || (adv && last)) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (adv) begin
      r_addr <= r_addr + 1'b1;
      r_col  <= w_col_end ? '0 : r_col + 1'b1;
      r_row  <= w_col_end ? r_row + 1'b1 : r_row;
    end
  end
endmodule

// File: rtl/placement_readback.sv
// placement_readback: scans grid and pos RAMs, cross-checks placement and streams node records
module placement_readback
  import placement_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int N_NODES = N_NODES_DEF,
  parameter int GRID_AW = GRID_AW_DEF,
  parameter int POS_AW  = POS_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               grid_re,
  output logic [GRID_AW-1:0] grid_addr,
  input  logic [DW-1:0]      grid_dout,
  output logic               pos_re,
  output logic [POS_AW-1:0]  pos_addr,
  input  logic [DW-1:0]      px_dout,
  input  logic [DW-1:0]      py_dout,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [DW-1:0]      rec_node,
  output logic [DW-1:0]      rec_x,
  output logic [DW-1:0]      rec_y,
  output logic               rec_err,
  output logic               busy,
  output logic               done,
  output logic [GRID_AW-1:0] placed_count,
  output logic [GRID_AW-1:0] err_count
);
  state_t              r_state, w_next;
  logic [DW-1:0]       r_cell, r_px, r_py;
  logic [POS_AW-1:0]   r_node;
  logic [N_NODES-1:0]  r_seen;
  rec_t                r_rec;
  logic                r_valid, r_busy, r_done;
  logic [GRID_AW-1:0]  r_placed, r_err;
  logic [GRID_AW-1:0]  w_row, w_col;
  logic                w_last, w_clr, w_adv, w_chk_err, w_miss, w_node_last, w_bad_id;

  function automatic logic [GRID_AW-1:0] sat_inc(input logic [GRID_AW-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  placement_grid_addr_gen #(.N(N), .AW(GRID_AW)) u_addr (
    .clk   (clk),
    .rst_n (reset),
    .clr   (w_clr),
    .adv   (w_adv),
    .row   (w_row),
    .col   (w_col),
    .addr  (grid_addr),
    .last  (w_last)
  );

  assign w_clr       = r_state == IDLE && start;
  assign w_adv       = r_state == G_NEXT;
  assign w_node_last = r_node == POS_AW'(N_NODES - 1);
  assign w_bad_id    = grid_dout != EMPTY && grid_dout >= DW'(N_NODES);
  assign w_chk_err   = (r_px != DW'(w_row)) | (r_py != DW'(w_col)) | r_seen[r_cell[POS_AW-1:0]];
  // second pass: stored but never seen on the grid, or a half-written coordinate pair
  assign w_miss      = (r_px != EMPTY && !r_seen[r_node]) || (r_px == EMPTY && r_py != EMPTY);

  assign grid_re      = r_state == G_RD;
  assign pos_re       = r_state == P_RD || r_state == S_RD;
  assign pos_addr     = r_state == S_RD ? r_node : r_cell[POS_AW-1:0];
  assign rec_valid    = r_valid;
  assign rec_node     = r_rec.node;
  assign rec_x        = r_rec.x;
  assign rec_y        = r_rec.y;
  assign rec_err      = r_rec.err;
  assign busy         = r_busy;
  assign done         = r_done;
  assign placed_count = r_placed;
  assign err_count    = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? G_RD : IDLE;
      G_RD:    w_next = G_WT;
      G_WT:    w_next = grid_dout == EMPTY ? G_NEXT : w_bad_id ? EMIT : P_RD;
      P_RD:    w_next = P_WT;
      P_WT:    w_next = CHECK;
      CHECK:   w_next = EMIT;
      EMIT:    w_next = rec_ready ? G_NEXT : EMIT;
      G_NEXT:  w_next = w_last ? S_RD : G_RD;
      S_RD:    w_next = S_WT;
      S_WT:    w_next = S_CHK;
      S_CHK:   w_next = w_node_last ? DONE : S_RD;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cell   <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_node   <= '0;
      r_seen   <= '0;
      r_rec    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_placed <= '0;
      r_err    <= '0;
    end else begin
      if (w_clr) begin
        r_seen   <= '0;
        r_rec    <= '0;
        r_valid  <= 1'b0;
        r_busy   <= 1'b1;
        r_done   <= 1'b0;
        r_placed <= '0;
        r_err    <= '0;
        r_node   <= '0;
      end
      if (r_state == G_WT) begin
        r_cell <= grid_dout;
        if (w_bad_id) begin
          r_rec   <= '{node: grid_dout, x: DW'(w_row), y: DW'(w_col), err: 1'b1};
          r_valid <= 1'b1;
          r_err   <= sat_inc(r_err, 1'b1);
        end
      end
      if (r_state == P_WT || r_state == S_WT) begin
        r_px <= px_dout;
        r_py <= py_dout;
      end
      if (r_state == CHECK) begin
        r_seen[r_cell[POS_AW-1:0]] <= 1'b1;
        r_placed <= sat_inc(r_placed, 1'b1);
        r_err    <= sat_inc(r_err, w_chk_err);
        r_rec    <= '{node: r_cell, x: DW'(w_row), y: DW'(w_col), err: w_chk_err};
        r_valid  <= 1'b1;
      end
      if (r_valid && rec_ready) r_valid <= 1'b0;
      if (r_state == S_CHK) begin
        r_err  <= sat_inc(r_err, w_miss);
        r_node <= w_node_last ? '0 : r_node + 1'b1;
      end
      if (r_state == DONE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_placement_readback.sv
// tb_placement_readback: directed vectors with hand-computed records, counts and scan latency
module tb_placement_readback;
  logic        clk = 1'b0;
  logic        reset, start, rec_ready;
  logic        grid_re, pos_re, rec_valid, rec_err, busy, done;
  logic [11:0] grid_addr, placed_count, err_count;
  logic [6:0]  pos_addr;
  logic [31:0] grid_dout, px_dout, py_dout, rec_node, rec_x, rec_y;
  logic [31:0] grid_mem [144];
  logic [31:0] px_mem [128];
  logic [31:0] py_mem [128];
  logic [96:0] recs [$];
  logic [96:0] snap;
  int n_vec = 0, n_mis = 0, n_grd = 0, n_pos = 0, cyc = 0;

  always #5 clk = ~clk;

  placement_readback dut (
    .clk(clk), .reset(reset), .start(start),
    .grid_re(grid_re), .grid_addr(grid_addr), .grid_dout(grid_dout),
    .pos_re(pos_re), .pos_addr(pos_addr), .px_dout(px_dout), .py_dout(py_dout),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_node(rec_node),
    .rec_x(rec_x), .rec_y(rec_y), .rec_err(rec_err),
    .busy(busy), .done(done), .placed_count(placed_count), .err_count(err_count)
  );

  always @(posedge clk) begin
    if (grid_re) grid_dout <= grid_mem[grid_addr];
    if (pos_re) begin
      px_dout <= px_mem[pos_addr];
      py_dout <= py_mem[pos_addr];
    end
  end

  always @(negedge clk) begin
    if (grid_re) n_grd++;
    if (pos_re) n_pos++;
    if (rec_valid && rec_ready) recs.push_back({rec_node, rec_x, rec_y, rec_err});
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 144; i++) grid_mem[i] = '1;
    for (int i = 0; i < 128; i++) begin
      px_mem[i] = '1;
      py_mem[i] = '1;
    end
  endtask

  task automatic run_scan(input int exp_cyc);
    int c;
    n_grd = 0;
    n_pos = 0;
    recs.delete();
    @(negedge clk);
    start = 1'b1;
    c = 0;
    do begin
      @(posedge clk);
      c++;
      #1 start = 1'b0;
    end while (!done && c < 5000);
    chk("scan_done", done, 1);
    chk("scan_cycles", c, exp_cyc);
    @(negedge clk);
    chk("scan_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    rec_ready = 1'b1;
    grid_dout = '0;
    px_dout = '0;
    py_dout = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_strobes", {grid_re, pos_re, rec_valid, busy, done}, 0);
    chk("rst_counts", {placed_count, err_count}, 0);
    chk("rst_rec", {rec_node, rec_x, rec_y, rec_err}, 0);
    chk("rst_addr", {grid_addr, pos_addr}, 0);
    reset = 1'b1;
    @(negedge clk);
    // all empty: 3*144 + 3*128 + 2
    run_scan(818);
    chk("empty_grid_reads", n_grd, 144);
    chk("empty_pos_reads", n_pos, 128);
    chk("empty_recs", recs.size(), 0);
    chk("empty_counts", {placed_count, err_count}, 0);
    // single good node at cell 43 = (3,7)
    grid_mem[43] = 5; px_mem[5] = 3; py_mem[5] = 7;
    run_scan(822);
    chk("one_recs", recs.size(), 1);
    if (recs.size() > 0) chk("one_rec0", recs[0], {32'd5, 32'd3, 32'd7, 1'b0});
    chk("one_placed", placed_count, 1);
    chk("one_err", err_count, 0);
    px_mem[5] = 4;
    run_scan(822);
    if (recs.size() > 0) chk("badx_rec0", recs[0], {32'd5, 32'd3, 32'd7, 1'b1});
    chk("badx_err", err_count, 1);
    // duplicate placement: cell 100 = (8,4)
    px_mem[5] = 3; grid_mem[100] = 5;
    run_scan(826);
    chk("dup_recs", recs.size(), 2);
    if (recs.size() > 1) begin
      chk("dup_rec0", recs[0], {32'd5, 32'd3, 32'd7, 1'b0});
      chk("dup_rec1", recs[1], {32'd5, 32'd8, 32'd4, 1'b1});
    end
    chk("dup_counts", {placed_count, err_count}, {12'd2, 12'd1});
    clear_mem();
    px_mem[9] = 2; py_mem[9] = 2;
    run_scan(818);
    chk("miss_recs", recs.size(), 0);
    chk("miss_counts", {placed_count, err_count}, {12'd0, 12'd1});
    clear_mem();
    grid_mem[0] = 200;
    run_scan(819);
    chk("range_recs", recs.size(), 1);
    if (recs.size() > 0) chk("range_rec0", recs[0], {32'd200, 32'd0, 32'd0, 1'b1});
    chk("range_counts", {placed_count, err_count}, {12'd0, 12'd1});
    clear_mem();
    py_mem[3] = 6;
    run_scan(818);
    chk("half_counts", {placed_count, err_count}, {12'd0, 12'd1});
    // backpressure, ignored start while busy, then asynchronous mid-scan reset
    clear_mem();
    grid_mem[43] = 5; px_mem[5] = 3; py_mem[5] = 7;
    rec_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!rec_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_valid", rec_valid, 1);
    snap = {rec_node, rec_x, rec_y, rec_err};
    chk("bp_snap", snap, {32'd5, 32'd3, 32'd7, 1'b0});
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(negedge clk);
      chk("bp_hold", {rec_valid, rec_node, rec_x, rec_y, rec_err}, {1'b1, snap});
    end
    start = 1'b0;
    chk("bp_counts", {busy, placed_count}, {1'b1, 12'd1});
    rec_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop", rec_valid, 0);
    repeat (20) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_strobes", {grid_re, pos_re, rec_valid, busy, done}, 0);
    chk("mid_counts", {placed_count, err_count}, 0);
    chk("mid_rec", {rec_node, rec_x, rec_y, rec_err}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_scan(822);
    chk("rescan_grid_reads", n_grd, 144);
    chk("rescan_recs", recs.size(), 1);
    if (recs.size() > 0) chk("rescan_rec0", recs[0], {32'd5, 32'd3, 32'd7, 1'b0});
    chk("rescan_counts", {placed_count, err_count}, {12'd1, 12'd0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
